// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM control unit.
// Includes the per-state control table used by multicycle_ctrl_fsm.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_RD1      = 2'b00;
  localparam logic [1:0] SRCA_PC       = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT   = 2'b10;
  localparam logic [1:0] SRCB_RD2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       next_pc;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.next_pc = 1'b1; c.ir_w = 1'b1; c.src_a = SRCA_PC;
                      c.src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
      S_DECODE: begin c.src_a = SRCA_PC; c.src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
      S_MEMADR: begin c.src_a = SRCA_RD1; c.src_b = SRCB_IMM; end
      S_MEMRD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      S_MEMWB:  begin c.result_src = RES_DATA; c.reg_w = 1'b1; end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      S_EXECR:  begin c.src_a = SRCA_RD1; c.src_b = SRCB_RD2; c.alu_op = 1'b1; end
      S_EXECI:  begin c.src_a = SRCA_RD1; c.src_b = SRCB_IMM; c.alu_op = 1'b1; end
      S_ALUWB:  begin c.result_src = RES_ALUOUT; c.reg_w = 1'b1; end
      S_BRANCH: begin c.src_a = SRCA_ALUOUT; c.src_b = SRCB_IMM;
                      c.result_src = RES_ALURESULT; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_cond_check.sv
// Combinational ARM condition-field evaluation against the NZCV flags.
module cond_check
  import multicycle_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM control unit: main FSM, NZCV register, predicated strobes.
// Define ILLEGAL_TRAP_EN to trap Op=11 / unsupported DP commands into HALT.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic       Illegal
);

  typedef struct packed {
    logic       pc_w;
    logic       ir_w;
    logic       reg_w;
    logic       mem_w;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_ctrl;
  } out_t;

  localparam out_t OUT_FETCH = '{pc_w: 1'b1, ir_w: 1'b1, reg_w: 1'b0, mem_w: 1'b0,
                                 adr_src: 1'b0, result_src: RES_ALURESULT, src_a: SRCA_PC,
                                 src_b: SRCB_FOUR, alu_ctrl: ALU_ADD};

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       illegal_q, illegal_d;
  out_t       out_q, out_d;
  ctrl_t      ctrl_s;
  logic       cond_ex_s;
  logic [3:0] cmd_s;
  logic       flag_w_nz_s, flag_w_cv_s;

  assign cmd_s       = Funct[4:1];
  assign flag_w_nz_s = Funct[0];
  assign flag_w_cv_s = Funct[0] & ((cmd_s == CMD_ADD) | (cmd_s == CMD_SUB));

  cond_check u_cond_check (
    .cond    (Cond),
    .nzcv    (flags_q),
    .cond_ex (cond_ex_s)
  );

`ifdef ILLEGAL_TRAP_EN
  logic illegal_op_s;
  assign illegal_op_s = (Op == 2'b11) |
                        ((Op == 2'b00) & (cmd_s != CMD_ADD) & (cmd_s != CMD_SUB) &
                         (cmd_s != CMD_AND) & (cmd_s != CMD_ORR));
`endif

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        cond_ex_d = cond_ex_s;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (illegal_op_s) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          illegal_d = illegal_q;
        end
`endif
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR, S_EXECI: begin
        state_d = S_ALUWB;
        // Flags latch only on the EXEC edge, predicated by the DECODE-time condition
        if (flag_w_nz_s && cond_ex_q) flags_d[3:2] = ALUFlags[3:2];
        else                          flags_d[3:2] = flags_q[3:2];
        if (flag_w_cv_s && cond_ex_q) flags_d[1:0] = ALUFlags[1:0];
        else                          flags_d[1:0] = flags_q[1:0];
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are registered: decode the control word of the state being entered.
  always_comb begin
    ctrl_s           = state_ctrl(state_d);
    out_d            = '0;
    out_d.ir_w       = ctrl_s.ir_w;
    out_d.adr_src    = ctrl_s.adr_src;
    out_d.result_src = ctrl_s.result_src;
    out_d.src_a      = ctrl_s.src_a;
    out_d.src_b      = ctrl_s.src_b;
    if (ctrl_s.alu_op) begin
      case (cmd_s)
        CMD_ADD: out_d.alu_ctrl = ALU_ADD;
        CMD_SUB: out_d.alu_ctrl = ALU_SUB;
        CMD_AND: out_d.alu_ctrl = ALU_AND;
        CMD_ORR: out_d.alu_ctrl = ALU_ORR;
        default: out_d.alu_ctrl = ALU_ADD;
      endcase
    end else begin
      out_d.alu_ctrl = ALU_ADD;
    end
    out_d.reg_w = ctrl_s.reg_w & cond_ex_d;
    out_d.mem_w = ctrl_s.mem_w & cond_ex_d;
    out_d.pc_w  = ctrl_s.next_pc |
                  (cond_ex_d & (ctrl_s.branch | (ctrl_s.reg_w & (Rd == 4'd15))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      flags_q   <= FLAG_RESET;
      cond_ex_q <= 1'b0;
      illegal_q <= 1'b0;
      out_q     <= OUT_FETCH;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      illegal_q <= illegal_d;
      out_q     <= out_d;
    end
  end

  // Strobes are masked while reset is asserted so no write escapes a reset.
  assign PCWrite    = out_q.pc_w  & ~reset;
  assign IRWrite    = out_q.ir_w  & ~reset;
  assign RegWrite   = out_q.reg_w & ~reset;
  assign MemWrite   = out_q.mem_w & ~reset;
  assign AdrSrc     = out_q.adr_src;
  assign ResultSrc  = out_q.result_src;
  assign ALUSrcA    = out_q.src_a;
  assign ALUSrcB    = out_q.src_b;
  assign ALUControl = out_q.alu_ctrl;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign Flags      = flags_q;
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags, Flags;
  logic [1:0] Op, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [5:0] Funct;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  mflags;
  logic [17:0] exp_v [0:7];
  logic [3:0]  exp_f [0:7];
  int          exp_len;
  logic [17:0] obs_v [0:7];
  logic [3:0]  obs_f [0:7];

  multicycle_ctrl_fsm #(.FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Flags(Flags), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // ARM conditions come in complementary pairs: evaluate the even one, invert for odd.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  // Expected output word: {Illegal, PCW, IRW, RegW, MemW, AdrSrc, Res, SrcA, SrcB, ALUCtl, ImmSrc, RegSrc}
  function automatic logic [17:0] ctl(input logic pcw, irw, rw, mw, adr,
                                      input logic [1:0] res, sa, sb, alu, op);
    return {1'b0, pcw, irw, rw, mw, adr, res, sa, sb, alu, op, op == 2'b01, op == 2'b10};
  endfunction

  task automatic model_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] af);
    logic ce, s, r15;
    logic [3:0] cmd, fl;
    logic [1:0] alu;
    ce  = cond_holds(c, mflags);
    cmd = fn[4:1];
    s   = fn[0];
    r15 = (rd == 4'd15);
    alu = (cmd == 4'b0100) ? 2'd0 : (cmd == 4'b0010) ? 2'd1 :
          (cmd == 4'b0000) ? 2'd2 : (cmd == 4'b1100) ? 2'd3 : 2'd0;
    fl = mflags;
    for (int k = 0; k < 8; k++) exp_f[k] = mflags;
    exp_v[0] = ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, op);
    exp_v[1] = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, op);
    case (op)
      2'b00: begin
        exp_len  = 4;
        exp_v[2] = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, fn[5] ? 2'b01 : 2'b00, alu, op);
        exp_v[3] = ctl(ce & r15, 1'b0, ce, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, op);
        if (ce && s) fl[3:2] = af[3:2];
        if (ce && s && (cmd == 4'b0100 || cmd == 4'b0010)) fl[1:0] = af[1:0];
        exp_f[3] = fl;
      end
      2'b01: begin
        exp_v[2] = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, op);
        if (fn[0]) begin
          exp_len  = 5;
          exp_v[3] = ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, op);
          exp_v[4] = ctl(ce & r15, 1'b0, ce, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, op);
        end else begin
          exp_len  = 4;
          exp_v[3] = ctl(1'b0, 1'b0, 1'b0, ce, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, op);
        end
      end
      2'b10: begin
        exp_len  = 3;
        exp_v[2] = ctl(ce, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, op);
      end
      default: exp_len = 2;
    endcase
    mflags = fl;
  endtask

  // Applies one instruction (entered in FETCH) and records outputs each cycle at negedge.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input logic [3:0] af, input int ncyc);
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    #1;
    for (int k = 0; k < ncyc; k++) begin
      obs_v[k] = {Illegal, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
      obs_f[k] = Flags;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    n_vec++;
    if ({Flags, Illegal} !== 5'b00000) begin
      n_err++; $display("FAIL reset_flags got %b/%b want 0000/0", Flags, Illegal);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 11'b11000011010) begin
      n_err++; $display("FAIL reset_fetch got %b want 11000011010",
                        {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
    end
    mflags = 4'b0000;
  endtask

  task automatic test_adds();
    model_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110);
    run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110, exp_len);
    for (int k = 0; k < exp_len; k++) begin
      n_vec++;
      if (obs_v[k] !== exp_v[k] || obs_f[k] !== exp_f[k]) begin
        n_err++; $display("FAIL adds cyc%0d ctl got %h want %h flags got %b want %b",
                          k, obs_v[k], exp_v[k], obs_f[k], exp_f[k]);
      end
    end
    n_vec++;
    if ({Flags, PCWrite, IRWrite} !== 6'b011011) begin
      n_err++; $display("FAIL adds_done flags/fetch got %b want 011011", {Flags, PCWrite, IRWrite});
    end
  endtask

  task automatic test_cond();
    logic [3:0] cc [2] = '{4'b0001, 4'b0000};
    for (int t = 0; t < 2; t++) begin
      model_instr(cc[t], 2'b00, 6'b000101, 4'd2, 4'b0010);
      run_instr(cc[t], 2'b00, 6'b000101, 4'd2, 4'b0010, exp_len);
      for (int k = 0; k < exp_len; k++) begin
        n_vec++;
        if (obs_v[k] !== exp_v[k] || obs_f[k] !== exp_f[k]) begin
          n_err++; $display("FAIL cond%0d cyc%0d ctl got %h want %h flags got %b want %b",
                            t, k, obs_v[k], exp_v[k], obs_f[k], exp_f[k]);
        end
      end
      n_vec++;
      if ({obs_v[3][14], Flags} !== ((t == 0) ? 5'b00110 : 5'b10010)) begin
        n_err++; $display("FAIL cond%0d regw/flags got %b want %b", t, {obs_v[3][14], Flags},
                          (t == 0) ? 5'b00110 : 5'b10010);
      end
    end
  endtask

  task automatic test_ldr_str();
    logic [5:0] fns [2] = '{6'b011001, 6'b011000};
    for (int t = 0; t < 2; t++) begin
      model_instr(4'b1110, 2'b01, fns[t], 4'd4, 4'b1111);
      run_instr(4'b1110, 2'b01, fns[t], 4'd4, 4'b1111, exp_len);
      for (int k = 0; k < exp_len; k++) begin
        n_vec++;
        if (obs_v[k] !== exp_v[k] || obs_f[k] !== exp_f[k]) begin
          n_err++; $display("FAIL mem%0d cyc%0d ctl got %h want %h flags got %b want %b",
                            t, k, obs_v[k], exp_v[k], obs_f[k], exp_f[k]);
        end
      end
    end
    n_vec++;
    if ({obs_v[3][13], obs_v[3][12], obs_v[2][13]} !== 3'b110) begin
      n_err++; $display("FAIL str_memwrite got %b want 110", {obs_v[3][13], obs_v[3][12], obs_v[2][13]});
    end
  endtask

  task automatic test_orrs_pc();
    logic [3:0] cs [3] = '{4'b1110, 4'b1110, 4'b1110};
    logic [5:0] fs [3] = '{6'b001001, 6'b011001, 6'b001000};
    logic [3:0] rs [3] = '{4'd3, 4'd5, 4'd15};
    logic [3:0] as [3] = '{4'b0101, 4'b1011, 4'b1111};
    for (int t = 0; t < 3; t++) begin
      model_instr(cs[t], 2'b00, fs[t], rs[t], as[t]);
      run_instr(cs[t], 2'b00, fs[t], rs[t], as[t], exp_len);
      for (int k = 0; k < exp_len; k++) begin
        n_vec++;
        if (obs_v[k] !== exp_v[k] || obs_f[k] !== exp_f[k]) begin
          n_err++; $display("FAIL orrs%0d cyc%0d ctl got %h want %h flags got %b want %b",
                            t, k, obs_v[k], exp_v[k], obs_f[k], exp_f[k]);
        end
      end
      if (t == 1) begin
        n_vec++;
        if ({Flags, obs_v[2][5:4]} !== 6'b100111) begin
          n_err++; $display("FAIL orrs_flags got %b want 100111", {Flags, obs_v[2][5:4]});
        end
      end
    end
    n_vec++;
    if (obs_v[3][16] !== 1'b1) begin
      n_err++; $display("FAIL add_r15_pcwrite got %b want 1", obs_v[3][16]);
    end
  endtask

  task automatic test_reset_mid();
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2; ALUFlags = 4'd0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_vec++;
    if (MemWrite !== 1'b1) begin
      n_err++; $display("FAIL rmid_in_memwr got %b want 1", MemWrite);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_vec++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        n_err++; $display("FAIL rmid_strobes%0d got %b want 0000", k, {PCWrite, IRWrite, RegWrite, MemWrite});
      end
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({Flags, PCWrite, IRWrite, MemWrite, AdrSrc} !== 8'b00001100) begin
      n_err++; $display("FAIL rmid_fetch got %b want 00001100", {Flags, PCWrite, IRWrite, MemWrite, AdrSrc});
    end
    mflags = 4'b0000;
  endtask

  task automatic test_op11();
`ifdef ILLEGAL_TRAP_EN
    Cond = 4'b1110; Op = 2'b11; Funct = 6'd0; Rd = 4'd0;
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if ({Illegal, PCWrite, IRWrite, RegWrite, MemWrite} !== 5'b10000) begin
        n_err++; $display("FAIL halt%0d got %b want 10000", k, {Illegal, PCWrite, IRWrite, RegWrite, MemWrite});
      end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({Illegal, IRWrite} !== 2'b01) begin
      n_err++; $display("FAIL halt_exit got %b want 01", {Illegal, IRWrite});
    end
    mflags = 4'b0000;
`else
    model_instr(4'b1110, 2'b11, 6'b001001, 4'd0, 4'b1111);
    run_instr(4'b1110, 2'b11, 6'b001001, 4'd0, 4'b1111, exp_len);
    for (int k = 0; k < exp_len; k++) begin
      n_vec++;
      if (obs_v[k] !== exp_v[k] || obs_f[k] !== exp_f[k]) begin
        n_err++; $display("FAIL op11 cyc%0d ctl got %h want %h flags got %b want %b",
                          k, obs_v[k], exp_v[k], obs_f[k], exp_f[k]);
      end
    end
    n_vec++;
    if ({Illegal, IRWrite} !== 2'b01) begin
      n_err++; $display("FAIL op11_fetch got %b want 01", {Illegal, IRWrite});
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
    logic [3:0] c, rd, af;
    logic [1:0] op;
    logic [5:0] fn;
    for (int i = 0; i < 60; i++) begin
      c  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      af = 4'($urandom);
      if ($urandom_range(0, 3) != 0) fn[4:1] = cmds[$urandom_range(0, 3)];
`ifdef ILLEGAL_TRAP_EN
      if (op == 2'b11) op = 2'b00;
      if (op == 2'b00) fn[4:1] = cmds[$urandom_range(0, 3)];
`endif
      model_instr(c, op, fn, rd, af);
      run_instr(c, op, fn, rd, af, exp_len);
      for (int k = 0; k < exp_len; k++) begin
        n_vec++;
        if (obs_v[k] !== exp_v[k] || obs_f[k] !== exp_f[k]) begin
          n_err++; $display("FAIL rand%0d c=%b op=%b fn=%b rd=%0d cyc%0d ctl got %h want %h flags got %b want %b",
                            i, c, op, fn, rd, k, obs_v[k], exp_v[k], obs_f[k], exp_f[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_cond();
    test_ldr_str();
    test_orrs_pc();
    test_reset_mid();
    test_op11();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
